// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receive front end for the core's memory-mapped UART read port.
// The asynchronous rx line is synchronised, deframed as 8N1 (LSB first) and
// the received bytes are buffered in a small FIFO. The head of the FIFO is
// presented combinationally, and the core pops one byte per data load.
//
// Parameters
//   CLK_FREQ    core clock frequency in Hz
//   BAUD        serial line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (>= 4)
//   FIFO_DEPTH  receive buffer entries, power of 2, at least 2
//
// Ports
//   clk        in   core clock, rising edge
//   reset      in   asynchronous reset, active low
//   rx         in   serial line, idle high, asynchronous to clk
//   rd_en      in   one-cycle pop strobe
//   clr_err    in   one-cycle strobe clearing overrun and frame_err
//   rx_data    out  byte at the FIFO head (meaningful while rx_valid)
//   rx_valid   out  FIFO non-empty
//   rx_full    out  FIFO holds FIFO_DEPTH entries
//   rx_busy    out  deframer not idle
//   overrun    out  sticky: completed byte dropped because FIFO was full
//   frame_err  out  sticky: stop bit sampled low
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_full,
   output logic       rx_busy,
   output logic       overrun,
   output logic       frame_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } state_e;

   // Synchroniser and deframer state
   logic             sync1_q;
   logic             sync2_q;
   logic             rx_s;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             busy_q;
   logic             ovr_q;
   logic             ferr_q;

   // FIFO state
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;

   logic fifo_full;
   logic fifo_empty;
   logic stop_sample;
   logic push;
   logic pop;
   logic drop_ovr;
   logic drop_ferr;

   assign rx_s       = sync2_q;
   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);

   // The stop-bit sample is the single point where a byte completes; the
   // push/overrun decision is taken here so a pop in the same cycle frees
   // the slot the new byte needs.
   assign stop_sample = (state_q == ST_STOP) && (cnt_q == BIT_END);
   assign push        = stop_sample && rx_s && (!fifo_full || rd_en);
   assign drop_ovr    = stop_sample && rx_s && fifo_full && !rd_en;
   assign drop_ferr   = stop_sample && !rx_s;
   assign pop         = rd_en && !fifo_empty;

   //---------------------------------------------------------------------------
   // Synchroniser, deframer FSM and sticky error flags
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;

         unique case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end

            // Re-check the line half a bit in: a line that is high again
            // was only a glitch and is ignored without raising a flag.
            ST_START: begin
               if (cnt_q == HALF_END) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q   <= ST_DATA;
                     bit_idx_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // Sampling one full bit period after the start midpoint keeps
            // every data sample at the centre of its bit.
            ST_DATA: begin
               if (cnt_q == BIT_END) begin
                  cnt_q              <= '0;
                  shift_q[bit_idx_q] <= rx_s;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_STOP: begin
               if (cnt_q == BIT_END) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // A held-low line (break) must return high before another start
            // bit can be recognised.
            ST_WAIT_HIGH: begin
               if (rx_s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         // Setting has priority over clearing so no error event is lost.
         if (drop_ovr) begin
            ovr_q <= 1'b1;
         end else if (clr_err) begin
            ovr_q <= 1'b0;
         end

         if (drop_ferr) begin
            ferr_q <= 1'b1;
         end else if (clr_err) begin
            ferr_q <= 1'b0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // FIFO pointer and occupancy next-state
   //---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   //---------------------------------------------------------------------------
   // FIFO storage and pointers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
         end
      end
   end

   assign rx_data   = mem_q[rd_ptr_q];
   assign rx_valid  = !fifo_empty;
   assign rx_full   = fifo_full;
   assign rx_busy   = busy_q;
   assign overrun   = ovr_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo, run at a shortened bit time
// (16 clocks per bit). Fixed vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_fifo;

   localparam int CLK_FREQ = 1600000;
   localparam int BAUD     = 100000;
   localparam int DEPTH    = 4;
   localparam int CPB      = CLK_FREQ / BAUD;     // 16
   localparam int HB       = CPB / 2;             // 8
   // Clock edges from the first edge after the start edge to the push.
   localparam int PUSH_LAT = HB + 9 * CPB + 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_full;
   logic       rx_busy;
   logic       overrun;
   logic       frame_err;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   uart_rx_fifo #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rd_en    (rd_en),
      .clr_err  (clr_err),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_full  (rx_full),
      .rx_busy  (rx_busy),
      .overrun  (overrun),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: byte queue plus sticky flags.
   logic [7:0] q[$];
   bit         m_ovr;
   bit         m_ferr;

   typedef struct {
      logic [7:0] d;
      bit         ok;
      bit         clr;
      int         npop;
      bit         valid;
      logic [7:0] head;
      bit         full;
      bit         ovr;
      bit         ferr;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // All drive tasks start and end 1 ns after a rising edge.
   task automatic bits(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit ok);
      bits(1'b0, CPB);
      for (int i = 0; i < 8; i++) bits(d[i], CPB);
      if (ok) begin
         bits(1'b1, CPB);
      end else begin
         bits(1'b0, 3 * CPB);   // stop bit low, line held low two more bits
      end
      bits(1'b1, CPB);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] d, input bit ok);
      if (!ok)                  m_ferr = 1'b1;
      else if (q.size() < DEPTH) q.push_back(d);
      else                      m_ovr = 1'b1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, rx_valid, q.size() > 0);
      if (q.size() > 0) chk({tag, ".data"}, rx_data, q[0]);
      chk({tag, ".full"},  rx_full, q.size() == DEPTH);
      chk({tag, ".ovr"},   overrun, m_ovr);
      chk({tag, ".ferr"},  frame_err, m_ferr);
      chk({tag, ".busy"},  rx_busy, 1'b0);
   endtask

   initial begin
      int lat;
      int t0;
      logic [7:0] rd;
      bit ok;
      int np;

      tbl[0]  = '{8'h03, 1'b1, 1'b0, 0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{8'h55, 1'b0, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{8'h11, 1'b1, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{8'h12, 1'b1, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{8'h13, 1'b1, 1'b0, 0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{8'h14, 1'b1, 1'b0, 0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{8'hFF, 1'b1, 1'b0, 0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{8'h80, 1'b1, 1'b1, 3, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{8'h7E, 1'b1, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

      rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; reset = 1'b0;

      // Reset state, with the line idle afterwards
      repeat (3) @(posedge clk);
      #1 chk("in_reset.valid", rx_valid, 1'b0);
      reset = 1'b1;
      bits(1'b1, 50);
      chk("rst.data",  rx_data, 8'h00);
      chk("rst.valid", rx_valid, 1'b0);
      chk("rst.full",  rx_full, 1'b0);
      chk("rst.busy",  rx_busy, 1'b0);
      chk("rst.ovr",   overrun, 1'b0);
      chk("rst.ferr",  frame_err, 1'b0);

      // Latency of first byte
      t0  = cyc;
      lat = -1;
      fork
         send_frame(8'h03, 1'b1);
         begin
            for (int k = 0; k < 12 * CPB; k++) begin
               @(negedge clk);
               if (rx_valid) begin
                  lat = cyc - (t0 + 1);
                  break;
               end
            end
         end
      join
      vectors++;
      if (lat < PUSH_LAT || lat > PUSH_LAT + 2) begin
         miscompares++;
         $display("FAIL latency: got %0d cycles, expected %0d..%0d", lat, PUSH_LAT, PUSH_LAT + 2);
      end
      chk("lat.data", rx_data, 8'h03);
      pop_one();
      chk("lat.pop_valid", rx_valid, 1'b0);

      // Short glitch is rejected as a false start
      bits(1'b0, 3);
      bits(1'b1, 4);
      chk("glitch.busy_mid", rx_busy, 1'b1);
      bits(1'b1, HB + 4);
      chk("glitch.busy", rx_busy, 1'b0);
      chk("glitch.valid", rx_valid, 1'b0);
      chk("glitch.ovr", overrun, 1'b0);
      chk("glitch.ferr", frame_err, 1'b0);

      // Table-driven sequence
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].clr) pulse_clr();
         send_frame(tbl[i].d, tbl[i].ok);
         for (int p = 0; p < tbl[i].npop; p++) pop_one();
         chk($sformatf("tbl%0d.valid", i), rx_valid, tbl[i].valid);
         if (tbl[i].valid) chk($sformatf("tbl%0d.data", i), rx_data, tbl[i].head);
         chk($sformatf("tbl%0d.full", i), rx_full, tbl[i].full);
         chk($sformatf("tbl%0d.ovr", i), overrun, tbl[i].ovr);
         chk($sformatf("tbl%0d.ferr", i), frame_err, tbl[i].ferr);
         chk($sformatf("tbl%0d.busy", i), rx_busy, 1'b0);
      end

      // Full FIFO, pop coincides with the fifth byte's stop sample
      do_reset();
      bits(1'b1, 5);
      for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
      chk("pop_at_stop.full_before", rx_full, 1'b1);
      fork
         send_frame(8'h15, 1'b1);
         begin
            repeat (PUSH_LAT) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
         end
      join
      chk("pop_at_stop.ovr", overrun, 1'b0);
      chk("pop_at_stop.full", rx_full, 1'b1);
      for (int i = 0; i < 4; i++) begin
         rd = 8'h12 + 8'(i);
         chk($sformatf("pop_at_stop.data%0d", i), rx_data, rd);
         pop_one();
      end
      chk("pop_at_stop.empty", rx_valid, 1'b0);

      // Reset in the middle of a frame
      send_frame(8'h42, 1'b1);
      bits(1'b0, CPB);
      bits(1'b1, CPB);
      bits(1'b0, HB);
      reset = 1'b0;
      #1;
      chk("midrst.valid", rx_valid, 1'b0);
      chk("midrst.busy", rx_busy, 1'b0);
      chk("midrst.data", rx_data, 8'h00);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      bits(1'b1, 2 * CPB);
      chk("midrst.idle_busy", rx_busy, 1'b0);
      chk("midrst.idle_valid", rx_valid, 1'b0);
      chk("midrst.idle_ferr", frame_err, 1'b0);
      send_frame(8'h5A, 1'b1);
      chk("midrst.next_valid", rx_valid, 1'b1);
      chk("midrst.next_data", rx_data, 8'h5A);
      pop_one();

      // Randomized frames against the reference model
      do_reset();
      bits(1'b1, 5);
      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            pulse_clr();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
         end
         rd = 8'($urandom);
         ok = ($urandom_range(0, 6) != 0);
         send_frame(rd, ok);
         model_frame(rd, ok);
         np = $urandom_range(0, 2);
         for (int p = 0; p < np; p++) begin
            pop_one();
            if (q.size() > 0) void'(q.pop_front());
         end
         bits(1'b1, $urandom_range(0, 10));
         check_model($sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
